dec_job_scheduler: RTL and testbench

Multi-requester job scheduler in front of the single AXI decompressor engine (`axi_io`). It accepts decompression job descriptors from `NUM_REQ` requesters, grants one at a time in round-robin order, and drives the engine's start, address and length inputs. It waits for engine completion and returns a per-requester completion pulse with status. It sits between the host-side command path and the engine's control ports; the engine's DMA ports are untouched.

---
 rtl/dec_job_scheduler_if.sv | 25 ++
 rtl/dec_job_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_dec_job_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_job_scheduler_if.sv
// Requester-side job/completion bundle for dec_job_scheduler.
// One lane per requester; descriptor fields are packed, lane i at [i*W +: W].
interface dec_job_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 64
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_src_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_des_addr;
    logic [NUM_REQ*32-1:0]     req_comp_len;
    logic [NUM_REQ*32-1:0]     req_decomp_len;
    logic [NUM_REQ-1:0]        cmp_valid;
    logic [1:0]                cmp_status;

    modport master (
        output req_valid, req_src_addr, req_des_addr, req_comp_len, req_decomp_len,
        input  req_ready, cmp_valid, cmp_status
    );

    modport slave (
        input  req_valid, req_src_addr, req_des_addr, req_comp_len, req_decomp_len,
        output req_ready, cmp_valid, cmp_status
    );
endinterface

// File: rtl/dec_job_scheduler.sv
// Round-robin job scheduler in front of the single decompressor engine.
// Optional watchdog: define DEC_WATCHDOG_EN to time out RUN and halt with a sticky fault.
module dec_job_scheduler #(
    parameter int unsigned NUM_REQ            = 4,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned TIMEOUT_CYCLES     = 1048576
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dec_job_scheduler_if.slave            job,
    output logic                          eng_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] eng_src_addr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] eng_des_addr,
    output logic [31:0]                   eng_comp_len,
    output logic [31:0]                   eng_decomp_len,
    input  logic                          eng_idle,
    input  logic                          eng_ready,
    input  logic                          eng_done,
    output logic                          busy,
    output logic [2:0]                    cur_id,
    output logic                          fault
);

    localparam int unsigned AW  = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned LW  = 32;
    localparam int unsigned IDW = 3;
    localparam int unsigned SW  = 2;
    localparam int unsigned GW  = 2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_ENG = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_CMPL     = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [SW-1:0] ST_OK      = 2'b00;
    localparam logic [SW-1:0] ST_ZERO    = 2'b01;
    localparam logic [SW-1:0] ST_TIMEOUT = 2'b10;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     last_grant_nxt;
    logic [IDW-1:0]     grant_idx;
    logic               grant_vld;
    logic [7:0]         vld_ext;
    logic [31:0]        cand;
    logic [AW-1:0]      sel_src;
    logic [AW-1:0]      sel_des;
    logic [LW-1:0]      sel_comp;
    logic [LW-1:0]      sel_decomp;
    logic               zero_len;
    logic [SW-1:0]      status_q;
    logic [SW-1:0]      status_nxt;
    logic [GW-1:0]      guard_cnt;
    logic [GW-1:0]      guard_nxt;
    logic [NUM_REQ-1:0] req_ready_d;
    logic [NUM_REQ-1:0] cmp_valid_d;
    logic [SW-1:0]      cmp_status_d;
    logic               eng_start_d;
    logic               latch_en;
    logic               fault_d;

`ifdef DEC_WATCHDOG_EN
    logic [31:0]        wd_cnt;
    logic [31:0]        wd_nxt;
`else
    logic               unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    assign vld_ext = 8'(job.req_valid);

    // Round-robin pick: first requester at or above last_grant+1, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(last_grant) + 32'(k) + 32'd1;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_vld && vld_ext[cand[2:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[2:0];
            end
        end
    end

    // Descriptor of the requester being granted this cycle.
    always_comb begin
        sel_src    = '0;
        sel_des    = '0;
        sel_comp   = '0;
        sel_decomp = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_src    = job.req_src_addr[i*AW +: AW];
                sel_des    = job.req_des_addr[i*AW +: AW];
                sel_comp   = job.req_comp_len[i*LW +: LW];
                sel_decomp = job.req_decomp_len[i*LW +: LW];
            end
        end
    end

    assign zero_len = (sel_comp == '0) || (sel_decomp == '0);

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        status_nxt     = status_q;
        guard_nxt      = guard_cnt;
        req_ready_d    = '0;
        cmp_valid_d    = '0;
        cmp_status_d   = '0;
        eng_start_d    = 1'b0;
        latch_en       = 1'b0;
`ifdef DEC_WATCHDOG_EN
        fault_d        = fault;
        wd_nxt         = wd_cnt;
`else
        fault_d        = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    req_ready_d = NUM_REQ'(1) << grant_idx;
                    latch_en    = 1'b1;
                    if (zero_len) begin
                        state_nxt  = S_CMPL;
                        status_nxt = ST_ZERO;
                    end else begin
                        state_nxt  = S_WAIT_ENG;
                        status_nxt = ST_OK;
                    end
                end
            end

            S_WAIT_ENG: begin
                if (eng_idle && eng_ready) begin
                    eng_start_d = 1'b1;
                    guard_nxt   = '0;
                    state_nxt   = S_RUN;
`ifdef DEC_WATCHDOG_EN
                    wd_nxt      = '0;
`endif
                end
            end

            S_RUN: begin
                // A done level left over from the previous job is masked for two cycles.
                if (guard_cnt < GW'(2)) begin
                    guard_nxt = guard_cnt + GW'(1);
                end else if (eng_done) begin
                    state_nxt  = S_CMPL;
                    status_nxt = ST_OK;
                end
`ifdef DEC_WATCHDOG_EN
                wd_nxt = wd_cnt + 32'd1;
                if ((state_nxt == S_RUN) && (wd_nxt >= 32'(TIMEOUT_CYCLES))) begin
                    state_nxt  = S_CMPL;
                    status_nxt = ST_TIMEOUT;
                end
`endif
            end

            S_CMPL: begin
                cmp_valid_d    = NUM_REQ'(1) << cur_id;
                cmp_status_d   = status_q;
                last_grant_nxt = cur_id;
                state_nxt      = S_IDLE;
`ifdef DEC_WATCHDOG_EN
                if (status_q == ST_TIMEOUT) begin
                    state_nxt = S_HALT;
                    fault_d   = 1'b1;
                end
`endif
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Control bookkeeping and the latched engine descriptor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= IDW'(NUM_REQ - 1);
            status_q       <= '0;
            guard_cnt      <= '0;
            cur_id         <= '0;
            eng_src_addr   <= '0;
            eng_des_addr   <= '0;
            eng_comp_len   <= '0;
            eng_decomp_len <= '0;
`ifdef DEC_WATCHDOG_EN
            wd_cnt         <= '0;
`endif
        end else begin
            last_grant <= last_grant_nxt;
            status_q   <= status_nxt;
            guard_cnt  <= guard_nxt;
`ifdef DEC_WATCHDOG_EN
            wd_cnt     <= wd_nxt;
`endif
            if (latch_en) begin
                cur_id         <= grant_idx;
                eng_src_addr   <= sel_src;
                eng_des_addr   <= sel_des;
                eng_comp_len   <= sel_comp;
                eng_decomp_len <= sel_decomp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job.req_ready  <= '0;
            job.cmp_valid  <= '0;
            job.cmp_status <= '0;
            eng_start      <= 1'b0;
            busy           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            job.req_ready  <= req_ready_d;
            job.cmp_valid  <= cmp_valid_d;
            job.cmp_status <= cmp_status_d;
            eng_start      <= eng_start_d;
            busy           <= (state_nxt != S_IDLE);
            fault          <= fault_d;
        end
    end

endmodule

// File: tb/tb_dec_job_scheduler.sv
// Self-checking bench for dec_job_scheduler: grant/completion scoreboard plus timed engine handshakes.
module tb_dec_job_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned AW      = 64;
    localparam int unsigned TMO     = 100;

    typedef struct packed {
        logic [2:0] id;
        logic [1:0] st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          eng_start;
    logic [AW-1:0] eng_src_addr;
    logic [AW-1:0] eng_des_addr;
    logic [31:0]   eng_comp_len;
    logic [31:0]   eng_decomp_len;
    logic          eng_idle;
    logic          eng_ready;
    logic          eng_done;
    logic          busy;
    logic [2:0]    cur_id;
    logic          fault;

    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_start = 0;
    exp_t exp_q[$];
    int   grant_q[$];
    exp_t mon_e;

    dec_job_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(AW)) ifc ();

    dec_job_scheduler #(
        .NUM_REQ           (NUM_REQ),
        .C_M_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job           (ifc),
        .eng_start     (eng_start),
        .eng_src_addr  (eng_src_addr),
        .eng_des_addr  (eng_des_addr),
        .eng_comp_len  (eng_comp_len),
        .eng_decomp_len(eng_decomp_len),
        .eng_idle      (eng_idle),
        .eng_ready     (eng_ready),
        .eng_done      (eng_done),
        .busy          (busy),
        .cur_id        (cur_id),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int i, input logic [63:0] s, input logic [63:0] d,
                            input logic [31:0] c, input logic [31:0] dc);
        ifc.req_src_addr[i*AW +: AW]   = s;
        ifc.req_des_addr[i*AW +: AW]   = d;
        ifc.req_comp_len[i*32 +: 32]   = c;
        ifc.req_decomp_len[i*32 +: 32] = dc;
    endtask

    task automatic wait_ready(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < 40) begin
            if (ifc.req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (eng_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_cmp(input int max, output int n);
        n = 0;
        while (n < max) begin
            if (ifc.cmp_valid != '0) break;
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard: every accept and every completion is matched against queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.req_ready != '0) begin
                if (grant_q.size() == 0) check("grant_unexpected", 64'(ifc.req_ready), 64'd0);
                else check("grant_order", 64'(ifc.req_ready), 64'd1 << grant_q.pop_front());
            end
            if (ifc.cmp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("cmp_unexpected", 64'(ifc.cmp_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cmp_valid", 64'(ifc.cmp_valid), 64'd1 << mon_e.id);
                    check("cmp_status", 64'(ifc.cmp_status), 64'(mon_e.st));
                end
            end
            if (eng_start) n_start++;
        end
    end

    initial begin
        bit ok;
        int n;
        int cnt;
        int s0;

        ifc.req_valid      = '0;
        ifc.req_src_addr   = '0;
        ifc.req_des_addr   = '0;
        ifc.req_comp_len   = '0;
        ifc.req_decomp_len = '0;
        eng_idle  = 1'b1;
        eng_ready = 1'b1;
        eng_done  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++)
            set_desc(i, 64'h1000_0000 + 64'(i) * 64'h100, 64'h2000_0000 + 64'(i) * 64'h100,
                     32'd64 + 32'(i), 32'd128 + 32'(i));

        repeat (3) tick();
        check("rst_req_ready", 64'(ifc.req_ready), 64'd0);
        check("rst_cmp_valid", 64'(ifc.cmp_valid), 64'd0);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cur_id", 64'(cur_id), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_src", eng_src_addr, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single job on requester 2.
        set_desc(2, 64'h1000, 64'h8000, 32'd4096, 32'd8192);
        grant_q.push_back(2);
        exp_q.push_back('{id: 3'd2, st: 2'b00});
        ifc.req_valid = 4'b0100;
        wait_ready(ok, n);
        check("single_ready_seen", 64'(ok), 64'd1);
        check("single_ready", 64'(ifc.req_ready), 64'b0100);
        ifc.req_valid = '0;
        tick();
        check("single_start", 64'(eng_start), 64'd1);
        check("single_src", eng_src_addr, 64'h1000);
        check("single_des", eng_des_addr, 64'h8000);
        check("single_comp", 64'(eng_comp_len), 64'd4096);
        check("single_decomp", 64'(eng_decomp_len), 64'd8192);
        check("single_cur_id", 64'(cur_id), 64'd2);
        tick();
        check("single_start_pulse", 64'(eng_start), 64'd0);
        tick();
        tick();
        eng_done = 1'b1;
        wait_cmp(20, n);
        check("single_cmp_lat", 64'(n), 64'd2);
        eng_done = 1'b0;
        tick();
        check("single_idle", 64'(busy), 64'd0);

        // Fairness with all requesters held; reset restores requester 0 priority.
        do_reset();
        for (int j = 0; j < 8; j++) begin
            grant_q.push_back(j % 4);
            exp_q.push_back('{id: 3'(j % 4), st: 2'b00});
        end
        ifc.req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            wait_ready(ok, n);
            check("fair_ready_seen", 64'(ok), 64'd1);
            if (j > 0) check("b2b_accept", 64'(n), 64'd1);
            wait_start(ok);
            check("fair_start_seen", 64'(ok), 64'd1);
            check("fair_cur_id", 64'(cur_id), 64'(j % 4));
            tick();
            tick();
            eng_done = 1'b1;
            wait_cmp(20, n);
            check("fair_cmp_lat", 64'(n), 64'd2);
            if (j == 7) ifc.req_valid = '0;
            eng_done = 1'b0;
        end

        // Engine not ready/idle: start held off until both are high.
        eng_ready = 1'b0;
        grant_q.push_back(0);
        exp_q.push_back('{id: 3'd0, st: 2'b00});
        ifc.req_valid = 4'b0001;
        wait_ready(ok, n);
        ifc.req_valid = '0;
        s0 = n_start;
        cnt = 0;
        for (int i = 0; i < 23; i++) begin
            if (i == 20) begin
                eng_ready = 1'b1;
                eng_idle  = 1'b0;
            end
            tick();
            if (eng_start) cnt++;
        end
        check("busy_no_start", 64'(cnt), 64'd0);
        eng_idle = 1'b1;
        tick();
        check("busy_start", 64'(eng_start), 64'd1);
        tick();
        check("busy_single_pulse", 64'(n_start - s0), 64'd1);
        tick();
        eng_done = 1'b1;
        wait_cmp(20, n);
        check("busy_cmp_lat", 64'(n), 64'd2);
        eng_done = 1'b0;

        // Stale done level present before the start pulse.
        eng_done = 1'b1;
        grant_q.push_back(1);
        exp_q.push_back('{id: 3'd1, st: 2'b00});
        ifc.req_valid = 4'b0010;
        wait_ready(ok, n);
        ifc.req_valid = '0;
        wait_start(ok);
        check("stale_start_seen", 64'(ok), 64'd1);
        tick();
        tick();
        check("stale_guard", 64'(ifc.cmp_valid), 64'd0);
        eng_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ifc.cmp_valid != '0) cnt++;
        end
        check("stale_no_cmp", 64'(cnt), 64'd0);
        eng_done = 1'b1;
        wait_cmp(20, n);
        check("stale_cmp_lat", 64'(n), 64'd2);
        eng_done = 1'b0;

        // Zero-length jobs complete at T+1 with status 01 and never start the engine.
        set_desc(1, 64'h3000, 64'h4000, 32'd0, 32'd512);
        set_desc(3, 64'h5000, 64'h6000, 32'd256, 32'd0);
        grant_q.push_back(1);
        exp_q.push_back('{id: 3'd1, st: 2'b01});
        grant_q.push_back(3);
        exp_q.push_back('{id: 3'd3, st: 2'b01});
        s0 = n_start;
        ifc.req_valid = 4'b0010;
        wait_ready(ok, n);
        ifc.req_valid = '0;
        tick();
        check("zero_cmp_valid", 64'(ifc.cmp_valid), 64'b0010);
        check("zero_cmp_status", 64'(ifc.cmp_status), 64'b01);
        ifc.req_valid = 4'b1000;
        wait_ready(ok, n);
        ifc.req_valid = '0;
        tick();
        check("zero_decomp_cmp", 64'(ifc.cmp_valid), 64'b1000);
        tick();
        tick();
        check("zero_no_start", 64'(n_start - s0), 64'd0);
        check("zero_idle", 64'(busy), 64'd0);
        set_desc(1, 64'h1000_0100, 64'h2000_0100, 32'd65, 32'd129);
        set_desc(3, 64'h1000_0300, 64'h2000_0300, 32'd67, 32'd131);

        // Reset mid-job clears everything immediately.
        grant_q.push_back(2);
        ifc.req_valid = 4'b0100;
        wait_ready(ok, n);
        ifc.req_valid = '0;
        wait_start(ok);
        rst_n = 1'b0;
        #1;
        check("midrst_start", 64'(eng_start), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cur_id", 64'(cur_id), 64'd0);
        check("midrst_src", eng_src_addr, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // After reset requester 0 wins, then the search wraps to requester 3.
        grant_q.push_back(0);
        exp_q.push_back('{id: 3'd0, st: 2'b00});
        grant_q.push_back(3);
        exp_q.push_back('{id: 3'd3, st: 2'b00});
        ifc.req_valid = 4'b1001;
        for (int j = 0; j < 2; j++) begin
            wait_ready(ok, n);
            if (j == 1) ifc.req_valid = '0;
            wait_start(ok);
            check("wrap_cur_id", 64'(cur_id), (j == 0) ? 64'd0 : 64'd3);
            tick();
            tick();
            eng_done = 1'b1;
            wait_cmp(20, n);
            eng_done = 1'b0;
        end

`ifdef DEC_WATCHDOG_EN
        // Engine never completes: timeout status, sticky fault, no further accepts.
        grant_q.push_back(0);
        exp_q.push_back('{id: 3'd0, st: 2'b10});
        ifc.req_valid = 4'b0001;
        wait_ready(ok, n);
        ifc.req_valid = '0;
        wait_start(ok);
        wait_cmp(300, n);
        check("wd_latency", 64'((n >= 95) && (n <= 110)), 64'd1);
        tick();
        check("wd_fault", 64'(fault), 64'd1);
        check("wd_busy", 64'(busy), 64'd1);
        ifc.req_valid = 4'b1111;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifc.req_ready != '0) cnt++;
        end
        check("halt_no_ready", 64'(cnt), 64'd0);
        ifc.req_valid = '0;
        do_reset();
        check("wd_fault_cleared", 64'(fault), 64'd0);
        check("wd_busy_cleared", 64'(busy), 64'd0);
`else
        check("fault_tied", 64'(fault), 64'd0);
`endif

        repeat (3) tick();
        check("sb_cmp_empty", 64'(exp_q.size()), 64'd0);
        check("sb_grant_empty", 64'(grant_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
